alu_dispatch: RTL and testbench

Command-side initiator for the 8-bit registered ALU. It accepts operation commands over a valid/ready handshake and holds the two operand registers A and B. It drives operands and op code into the ALU, waits out the ALU's registered latency, and captures the result. It then writes the result back to A or B, or returns a compare flag, and presents a held response to the sequencer. It sits between the processor control FSM and the ALU.

---
 rtl/alu_dispatch.sv | 118 +++++++++++
 tb/tb_alu_dispatch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Command-side initiator for the 8-bit registered ALU: accepts load/op commands,
// owns operand registers A/B, waits out ALU latency, writes back and holds a response.
module alu_dispatch #(
    parameter int ALU_LATENCY = 1,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_LOAD,
    input  logic [3:0]            CMD_OP,
    input  logic                  CMD_DEST,
    input  logic [7:0]            CMD_IMM,
    output logic [7:0]            ALU_IN_A,
    output logic [7:0]            ALU_IN_B,
    output logic [3:0]            ALU_OP_CODE,
    input  logic [7:0]            ALU_RESULT,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [7:0]            RSP_DATA,
    output logic                  RSP_FLAG,
    output logic [7:0]            REG_A,
    output logic [7:0]            REG_B,
    output logic [STAT_WIDTH-1:0] STAT_OPS
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

    // WAIT spans ALU_LATENCY-1 cycles; the counter runs down to zero inclusive.
    localparam logic [1:0] WAIT_INIT = (ALU_LATENCY >= 2) ? 2'(ALU_LATENCY - 2) : 2'd0;

    state_t                state_reg;
    logic [1:0]            wait_reg;
    logic [3:0]            op_reg;
    logic                  dest_reg;
    logic [7:0]            reg_a_reg;
    logic [7:0]            reg_b_reg;
    logic [7:0]            rsp_data_reg;
    logic                  rsp_flag_reg;
    logic [STAT_WIDTH-1:0] stat_reg;
    logic                  is_compare;

    assign is_compare = (op_reg == 4'h9) || (op_reg == 4'hA) || (op_reg == 4'hB);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            wait_reg     <= 2'd0;
            op_reg       <= 4'hF;
            dest_reg     <= 1'b0;
            reg_a_reg    <= 8'h00;
            reg_b_reg    <= 8'h00;
            rsp_data_reg <= 8'h00;
            rsp_flag_reg <= 1'b0;
            stat_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (CMD_VALID) begin
                        if (CMD_LOAD) begin
                            if (CMD_DEST) reg_b_reg <= CMD_IMM;
                            else          reg_a_reg <= CMD_IMM;
                            rsp_data_reg <= CMD_IMM;
                            rsp_flag_reg <= 1'b0;
                            state_reg    <= RESP;
                        end else begin
                            op_reg    <= CMD_OP;
                            dest_reg  <= CMD_DEST;
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (ALU_LATENCY <= 1) begin
                        state_reg <= CAPTURE;
                    end else begin
                        wait_reg  <= WAIT_INIT;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_reg == 2'd0) state_reg <= CAPTURE;
                    else                  wait_reg  <= wait_reg - 2'd1;
                end
                CAPTURE: begin
                    rsp_data_reg <= ALU_RESULT;
                    // Compares report through the flag only; operands stay intact.
                    if (is_compare) begin
                        rsp_flag_reg <= ALU_RESULT[0];
                    end else begin
                        rsp_flag_reg <= 1'b0;
                        if (dest_reg) reg_b_reg <= ALU_RESULT;
                        else          reg_a_reg <= ALU_RESULT;
                    end
                    if (stat_reg != {STAT_WIDTH{1'b1}}) stat_reg <= stat_reg + 1'b1;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (RSP_READY) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign CMD_READY   = (state_reg == IDLE) && !RESET;
    assign RSP_VALID   = (state_reg == RESP);
    assign RSP_DATA    = rsp_data_reg;
    assign RSP_FLAG    = rsp_flag_reg;
    assign ALU_OP_CODE = op_reg;
    assign ALU_IN_A    = reg_a_reg;
    assign ALU_IN_B    = reg_b_reg;
    assign REG_A       = reg_a_reg;
    assign REG_B       = reg_b_reg;
    assign STAT_OPS    = stat_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: latency-1 and latency-3 instances, each fed by a
// behavioural registered ALU; expected values are hand-computed constants.
module tb_alu_dispatch;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    logic cmd_valid, cmd_load, cmd_dest, rsp_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_imm;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_flag1;
    logic [7:0]  alu_a1, alu_b1, alu_res1, rsp_data1, reg_a1, reg_b1;
    logic [3:0]  alu_op1;
    logic [15:0] stat1;
    logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_flag3;
    logic [7:0]  alu_a3, alu_b3, alu_res3, rsp_data3, reg_a3, reg_b3;
    logic [3:0]  alu_op3;
    logic [15:0] stat3;

    assign cmd_valid1 = cmd_valid & ~sel;
    assign cmd_valid3 = cmd_valid & sel;

    alu_dispatch #(.ALU_LATENCY(1), .STAT_WIDTH(16)) dut (
        .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid1), .CMD_READY(cmd_ready1),
        .CMD_LOAD(cmd_load), .CMD_OP(cmd_op), .CMD_DEST(cmd_dest), .CMD_IMM(cmd_imm),
        .ALU_IN_A(alu_a1), .ALU_IN_B(alu_b1), .ALU_OP_CODE(alu_op1), .ALU_RESULT(alu_res1),
        .RSP_VALID(rsp_valid1), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data1), .RSP_FLAG(rsp_flag1),
        .REG_A(reg_a1), .REG_B(reg_b1), .STAT_OPS(stat1)
    );

    alu_dispatch #(.ALU_LATENCY(3), .STAT_WIDTH(16)) dut3 (
        .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid3), .CMD_READY(cmd_ready3),
        .CMD_LOAD(cmd_load), .CMD_OP(cmd_op), .CMD_DEST(cmd_dest), .CMD_IMM(cmd_imm),
        .ALU_IN_A(alu_a3), .ALU_IN_B(alu_b3), .ALU_OP_CODE(alu_op3), .ALU_RESULT(alu_res3),
        .RSP_VALID(rsp_valid3), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data3), .RSP_FLAG(rsp_flag3),
        .REG_A(reg_a3), .REG_B(reg_b3), .STAT_OPS(stat3)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a * b;
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a + 8'd1;
            4'h6: return a ^ b;
            4'h7: return a << 1;
            4'h8: return a >> 1;
            4'h9: return {7'd0, a == b};
            4'hA: return {7'd0, a > b};
            4'hB: return {7'd0, a < b};
            default: return a;
        endcase
    endfunction

    // Registered ALU models sampling every edge, sharing the reset.
    logic [7:0] pipe3 [0:2];
    always @(posedge clk) begin
        if (reset) begin
            alu_res1 <= 8'h00;
            pipe3[0] <= 8'h00; pipe3[1] <= 8'h00; pipe3[2] <= 8'h00;
        end else begin
            alu_res1 <= alu_f(alu_op1, alu_a1, alu_b1);
            pipe3[0] <= alu_f(alu_op3, alu_a3, alu_b3);
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign alu_res3 = pipe3[2];

    logic        cmd_ready_m, rsp_valid_m, rsp_flag_m;
    logic [7:0]  rsp_data_m, reg_a_m, reg_b_m;
    logic [15:0] stat_m;
    assign cmd_ready_m = sel ? cmd_ready3 : cmd_ready1;
    assign rsp_valid_m = sel ? rsp_valid3 : rsp_valid1;
    assign rsp_flag_m  = sel ? rsp_flag3  : rsp_flag1;
    assign rsp_data_m  = sel ? rsp_data3  : rsp_data1;
    assign reg_a_m     = sel ? reg_a3     : reg_a1;
    assign reg_b_m     = sel ? reg_b3     : reg_b1;
    assign stat_m      = sel ? stat3      : stat1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic ld, input logic [3:0] op, input logic dst, input logic [7:0] imm);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_dest = dst; cmd_imm = imm;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until RSP_VALID is visible.
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid_m && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic ld, input logic [3:0] op, input logic dst, input logic [7:0] imm,
                       output int edges, output logic [7:0] data, output logic flag);
        send(ld, op, dst, imm);
        wait_rsp(edges);
        data = rsp_data_m;
        flag = rsp_flag_m;
        $display("txn sel=%0d load=%0d op=%h dest=%0d imm=%h -> edges=%0d data=%h flag=%0d",
                 sel, ld, op, dst, imm, edges, data, flag);
        release_rsp();
    endtask

    int         e;
    logic [7:0] d;
    logic       f;

    initial begin
        reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0;
        cmd_op = 4'h0; cmd_dest = 1'b0; cmd_imm = 8'h00; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready1), 'h0);
        check("rst_rsp_valid", 32'(rsp_valid1), 'h0);
        check("rst_reg_a", 32'(reg_a1), 'h00);
        check("rst_op_code", 32'(alu_op1), 'hF);
        check("rst_stat", 32'(stat1), 'h0);
        reset = 1'b0;

        // Add with writeback to A
        txn(1'b1, 4'h0, 1'b0, 8'h05, e, d, f);
        check("load_edges", 32'(e), 0);
        check("load_data", 32'(d), 'h05);
        txn(1'b1, 4'h0, 1'b1, 8'h03, e, d, f);
        txn(1'b0, 4'h0, 1'b0, 8'h00, e, d, f);
        check("add_edges", 32'(e), 2);
        check("add_data", 32'(d), 'h08);
        check("add_flag", 32'(f), 0);
        check("add_reg_a", 32'(reg_a1), 'h08);
        check("add_alu_in_a", 32'(alu_a1), 'h08);
        check("add_reg_b", 32'(reg_b1), 'h03);
        check("add_stat", 32'(stat1), 1);

        // Subtract wraps, writeback to B
        txn(1'b1, 4'h0, 1'b0, 8'h02, e, d, f);
        txn(1'b1, 4'h0, 1'b1, 8'h05, e, d, f);
        txn(1'b0, 4'h1, 1'b1, 8'h00, e, d, f);
        check("sub_data", 32'(d), 'hFD);
        check("sub_reg_b", 32'(reg_b1), 'hFD);
        check("sub_reg_a", 32'(reg_a1), 'h02);

        // Multiply truncates to 8 bits
        txn(1'b1, 4'h0, 1'b0, 8'h10, e, d, f);
        txn(1'b1, 4'h0, 1'b1, 8'h10, e, d, f);
        txn(1'b0, 4'h2, 1'b0, 8'h00, e, d, f);
        check("mul_data", 32'(d), 'h00);
        check("mul_reg_a", 32'(reg_a1), 'h00);

        // Compares: flag only, registers untouched
        txn(1'b1, 4'h0, 1'b0, 8'h07, e, d, f);
        txn(1'b1, 4'h0, 1'b1, 8'h03, e, d, f);
        txn(1'b0, 4'hA, 1'b0, 8'h00, e, d, f);
        check("gt_flag", 32'(f), 1);
        check("gt_data", 32'(d), 'h01);
        txn(1'b0, 4'hB, 1'b1, 8'h00, e, d, f);
        check("lt_flag", 32'(f), 0);
        check("lt_data", 32'(d), 'h00);
        check("cmp_reg_a", 32'(reg_a1), 'h07);
        check("cmp_reg_b", 32'(reg_b1), 'h03);
        check("cmp_stat", 32'(stat1), 5);

        // Back-pressure: response held, no second accept
        send(1'b0, 4'h0, 1'b0, 8'h00);
        wait_rsp(e);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_dest = 1'b0; cmd_imm = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid1), 1);
            check("hold_data", 32'(rsp_data1), 'h0A);
            check("hold_flag", 32'(rsp_flag1), 0);
            check("hold_cmd_ready", 32'(cmd_ready1), 0);
        end
        cmd_valid = 1'b0;
        release_rsp();
        check("post_hs_cmd_ready", 32'(cmd_ready1), 1);
        check("post_hs_rsp_valid", 32'(rsp_valid1), 0);
        check("hold_no_accept", 32'(reg_a1), 'h0A);
        check("hold_stat", 32'(stat1), 6);
        $display("txn sel=0 backpressure op=0 -> data=%h", rsp_data1);

        // Reset during CAPTURE aborts the operation
        txn(1'b1, 4'h0, 1'b0, 8'h05, e, d, f);
        txn(1'b1, 4'h0, 1'b1, 8'h03, e, d, f);
        send(1'b0, 4'h0, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cmd_ready", 32'(cmd_ready1), 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid1), 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready1), 1);
        check("abort_rsp_valid", 32'(rsp_valid1), 0);
        check("abort_reg_a", 32'(reg_a1), 'h00);
        check("abort_stat", 32'(stat1), 0);
        $display("txn sel=0 reset-abort op=0 -> reg_a=%h stat=%0d", reg_a1, stat1);

        // Latency-3 instance: increment wraps, response 4 edges after accept
        sel = 1'b1;
        txn(1'b1, 4'h0, 1'b0, 8'hFF, e, d, f);
        txn(1'b0, 4'h5, 1'b0, 8'h00, e, d, f);
        check("lat3_edges", 32'(e), 4);
        check("lat3_data", 32'(d), 'h00);
        check("lat3_reg_a", 32'(reg_a_m), 'h00);
        check("lat3_stat", 32'(stat_m), 1);
        check("lat3_reg_b", 32'(reg_b_m), 'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
